// File: rtl/adder_cg_ctrl_if.sv
// Operand and clock-gate status bundle between the operand source and adder_cg_ctrl.
// The master modport is the operand source; the slave modport is the controller.
interface adder_cg_ctrl_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) ();
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             carry_in;
    logic             force_on;
    logic             cnt_clr;
    logic             cg;
    logic             gated_clk;
    logic             op_ready;
    logic [1:0]       cg_state;
    logic [CNT_W-1:0] gated_cycles;

    modport master (
        output a_in, b_in, carry_in, force_on, cnt_clr,
        input  cg, gated_clk, op_ready, cg_state, gated_cycles
    );

    modport slave (
        input  a_in, b_in, carry_in, force_on, cnt_clr,
        output cg, gated_clk, op_ready, cg_state, gated_cycles
    );
endinterface

// File: rtl/adder_cg_ctrl.sv
// Clock-gating controller for the upper adder segment: gates the MSB clock after a run of
// provably-zero cycles. Define CG_ICG_EN for a latch-based glitch-free gate on gated_clk.
module adder_cg_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SEG         = 8,
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    adder_cg_ctrl_if.slave bus
);
    localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WakeW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_CYCLES - 1);
    localparam logic [WakeW-1:0] WakeMax = WakeW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        StOn    = 2'd0,
        StGated = 2'd1,
        StWake  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [WakeW-1:0] wake_q, wake_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic             cg_q;
    logic             op_ready;
    logic             need;
    logic [SEG:0]     low_sum;

    // Upper byte is needed if either operand has upper bits set or the lower segment carries out.
    assign low_sum = {1'b0, bus.a_in[SEG-1:0]} + {1'b0, bus.b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, bus.carry_in};
    assign need = (|bus.a_in[WIDTH-1:SEG]) | (|bus.b_in[WIDTH-1:SEG])
                | (low_sum >= {1'b1, {SEG{1'b0}}});

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        wake_d   = wake_q;
        op_ready = 1'b1;
        unique case (state_q)
            StOn: begin
                if (need || bus.force_on) begin
                    idle_d = '0;
                end else if (idle_q == IdleMax) begin
                    state_d = StGated;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            StGated: begin
                if (need) begin
                    op_ready = 1'b0;
                end
                if (need || bus.force_on) begin
                    state_d = StWake;
                    wake_d  = '0;
                end
            end
            StWake: begin
                op_ready = 1'b0;
                if (wake_q == WakeMax) begin
                    state_d = StOn;
                    wake_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: state_d = StOn;
        endcase
    end

    always_comb begin
        gcnt_d = gcnt_q;
        if (bus.cnt_clr) begin
            gcnt_d = '0;
        end else if (state_q == StGated && gcnt_q != '1) begin
            gcnt_d = gcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StOn;
            idle_q  <= '0;
            wake_q  <= '0;
            gcnt_q  <= '0;
            cg_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
            gcnt_q  <= gcnt_d;
            cg_q    <= (state_d != StGated);
        end
    end

    assign bus.cg           = cg_q;
    assign bus.op_ready     = op_ready;
    assign bus.cg_state     = state_q;
    assign bus.gated_cycles = gcnt_q;

`ifdef CG_ICG_EN
    logic en_lat;

    // Enable is frozen while clk is high so gated pulses are never truncated.
    always_latch begin
        if (!clk) begin
            en_lat = cg_q;
        end
    end

    assign bus.gated_clk = clk & en_lat;
`else
    assign bus.gated_clk = clk & cg_q;
`endif
endmodule
